regfile_scoreboard: RTL and testbench

Parametrised general-purpose register file for the pipelined MIPS core, with two combinational read ports, one write-back port, optional hardwired-zero register 0, optional write-to-read bypass, and an integrated busy-bit scoreboard. It sits between decode (register reads plus issue of new destination writes) and write-back, and produces the decode-stage stall for RAW and WAW hazards on in-flight loads and long-latency results.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard_if.sv | 32 +++
 rtl/regfile_busy_sb.sv | 57 +++++
 rtl/regfile_scoreboard.sv | 68 ++++++
 tb/tb_regfile_scoreboard.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file with busy-bit scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_AW    = $clog2(DEF_DEPTH);
  localparam int unsigned ZERO_IDX  = 0;

  typedef logic [DEF_AW-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back bundle: master drives indices, issue and write-back; slave returns data, stall and busy bits.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic [AW-1:0]    rs;
  logic [AW-1:0]    rt;
  logic             use_rs;
  logic             use_rt;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             write;
  logic [AW-1:0]    rd;
  logic [WIDTH-1:0] entradaWb;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic [DEPTH-1:0] busy_vec;

  modport master (
    output rs, rt, use_rs, use_rt, issue_valid, issue_rd, write, rd, entradaWb,
    input  a, b, stall, busy_vec
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, issue_valid, issue_rd, write, rd, entradaWb,
    output a, b, stall, busy_vec
  );
endinterface

// File: rtl/regfile_busy_sb.sv
// Busy-bit scoreboard: tracks outstanding producers and raises the decode stall on RAW/WAW hazards.
module regfile_busy_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs_i,
  input  logic [AW-1:0]    rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rd_i,
  input  logic             write_i,
  input  logic [AW-1:0]    rd_i,
  output logic             stall_o,
  output logic [DEPTH-1:0] busy_vec_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [DEPTH-1:0] ebusy_c;
  logic             wb_clr_c;
  logic             accept_c;
  logic             stall_c;

  // Effective busy, stall, and next busy state (set after clear so a new producer wins).
  always_comb begin
    ebusy_c  = busy_q;
    wb_clr_c = write_i & ~(ZERO_REG & (rd_i == AW'(ZERO_IDX)));
    if (BYPASS && wb_clr_c) ebusy_c[rd_i] = 1'b0;
    if (ZERO_REG) ebusy_c[ZERO_IDX] = 1'b0;

    stall_c = (use_rs_i & ebusy_c[rs_i]) |
              (use_rt_i & ebusy_c[rt_i]) |
              (issue_valid_i & ebusy_c[issue_rd_i]);
    if (rst) stall_c = 1'b0;

    accept_c = issue_valid_i & ~stall_c;
    busy_d   = busy_q;
    if (wb_clr_c) busy_d[rd_i] = 1'b0;
    if (accept_c && !(ZERO_REG && (issue_rd_i == AW'(ZERO_IDX)))) busy_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign stall_o    = stall_c;
  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write-back port, optional zero register and bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 Clk,
  input  logic                 rst,
  regfile_scoreboard_if.slave  bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en_c;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;

  assign wr_en_c = bus.write & ~(ZERO_REG & (bus.rd == AW'(ZERO_IDX)));

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_c) begin
      mem_q[bus.rd] <= bus.entradaWb;
    end
  end

  // Read muxes: array, then same-cycle forward, then zero register; all forced low in reset.
  always_comb begin
    a_c = mem_q[bus.rs];
    b_c = mem_q[bus.rt];
    if (BYPASS && wr_en_c && (bus.rd == bus.rs)) a_c = bus.entradaWb;
    if (BYPASS && wr_en_c && (bus.rd == bus.rt)) b_c = bus.entradaWb;
    if (ZERO_REG && (bus.rs == AW'(ZERO_IDX))) a_c = '0;
    if (ZERO_REG && (bus.rt == AW'(ZERO_IDX))) b_c = '0;
    if (rst) begin
      a_c = '0;
      b_c = '0;
    end
  end

  assign bus.a = a_c;
  assign bus.b = b_c;

  regfile_busy_sb #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_busy_sb (
    .Clk           (Clk),
    .rst           (rst),
    .rs_i          (bus.rs),
    .rt_i          (bus.rt),
    .use_rs_i      (bus.use_rs),
    .use_rt_i      (bus.use_rt),
    .issue_valid_i (bus.issue_valid),
    .issue_rd_i    (bus.issue_rd),
    .write_i       (bus.write),
    .rd_i          (bus.rd),
    .stall_o       (bus.stall),
    .busy_vec_o    (bus.busy_vec)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Three configurations driven by shared stimulus, checked against an array/bit-vector reference model.
module tb_regfile_scoreboard;

  logic Clk = 1'b0;
  logic rst;
  always #5 Clk = ~Clk;

  logic [4:0]  rs_s, rt_s, issue_rd_s, rd_s;
  logic        use_rs_s, use_rt_s, issue_valid_s, write_s;
  logic [31:0] data_s;

  int checks = 0;
  int errors = 0;

  // Config 0: 32x32 zero+bypass, 1: 32x32 zero no bypass, 2: 16x8 no zero, bypass.
  int cW[3] = '{32, 32, 16};
  int cD[3] = '{32, 32, 8};
  bit cZ[3] = '{1'b1, 1'b1, 1'b0};
  bit cB[3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] mreg  [3][32];
  bit          mbusy [3][32];

  regfile_scoreboard_if #(.WIDTH(32), .DEPTH(32)) bus0 ();
  regfile_scoreboard_if #(.WIDTH(32), .DEPTH(32)) bus1 ();
  regfile_scoreboard_if #(.WIDTH(16), .DEPTH(8))  bus2 ();

  assign bus0.rs = rs_s;            assign bus1.rs = rs_s;            assign bus2.rs = rs_s[2:0];
  assign bus0.rt = rt_s;            assign bus1.rt = rt_s;            assign bus2.rt = rt_s[2:0];
  assign bus0.use_rs = use_rs_s;    assign bus1.use_rs = use_rs_s;    assign bus2.use_rs = use_rs_s;
  assign bus0.use_rt = use_rt_s;    assign bus1.use_rt = use_rt_s;    assign bus2.use_rt = use_rt_s;
  assign bus0.issue_valid = issue_valid_s;
  assign bus1.issue_valid = issue_valid_s;
  assign bus2.issue_valid = issue_valid_s;
  assign bus0.issue_rd = issue_rd_s; assign bus1.issue_rd = issue_rd_s; assign bus2.issue_rd = issue_rd_s[2:0];
  assign bus0.write = write_s;      assign bus1.write = write_s;      assign bus2.write = write_s;
  assign bus0.rd = rd_s;            assign bus1.rd = rd_s;            assign bus2.rd = rd_s[2:0];
  assign bus0.entradaWb = data_s;   assign bus1.entradaWb = data_s;   assign bus2.entradaWb = data_s[15:0];

  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (.Clk(Clk), .rst(rst), .bus(bus0));
  regfile_scoreboard #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (.Clk(Clk), .rst(rst), .bus(bus1));
  regfile_scoreboard #(.WIDTH(16), .DEPTH(8),  .ZERO_REG(1'b0), .BYPASS(1'b1)) dut2 (.Clk(Clk), .rst(rst), .bus(bus2));

  logic [31:0] out_a[3], out_b[3], out_busy[3];
  logic        out_stall[3];
  assign out_a[0] = bus0.a;  assign out_a[1] = bus1.a;  assign out_a[2] = {16'h0, bus2.a};
  assign out_b[0] = bus0.b;  assign out_b[1] = bus1.b;  assign out_b[2] = {16'h0, bus2.b};
  assign out_stall[0] = bus0.stall; assign out_stall[1] = bus1.stall; assign out_stall[2] = bus2.stall;
  assign out_busy[0] = bus0.busy_vec; assign out_busy[1] = bus1.busy_vec;
  assign out_busy[2] = {24'h0, bus2.busy_vec};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ix(input int k, input logic [4:0] v);
    return int'(v) % cD[k];
  endfunction

  function automatic logic [31:0] m_dat(input int k);
    return (cW[k] == 32) ? data_s : {16'h0, data_s[15:0]};
  endfunction

  function automatic bit m_ebusy(input int k, input int i);
    if (cZ[k] && i == 0) return 1'b0;
    if (cB[k] && write_s && ix(k, rd_s) == i) return 1'b0;
    return mbusy[k][i];
  endfunction

  function automatic logic [31:0] m_read(input int k, input int i);
    if (cZ[k] && i == 0) return 32'h0;
    if (cB[k] && write_s && ix(k, rd_s) == i) return m_dat(k);
    return mreg[k][i];
  endfunction

  function automatic bit m_stall(input int k);
    return (use_rs_s && m_ebusy(k, ix(k, rs_s))) ||
           (use_rt_s && m_ebusy(k, ix(k, rt_s))) ||
           (issue_valid_s && m_ebusy(k, ix(k, issue_rd_s)));
  endfunction

  function automatic logic [31:0] m_busyvec(input int k);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < cD[k]; i++) v[i] = mbusy[k][i];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) begin
        mreg[k][i]  = 32'h0;
        mbusy[k][i] = 1'b0;
      end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit acc = issue_valid_s && !m_stall(k);
      int w   = ix(k, rd_s);
      int d   = ix(k, issue_rd_s);
      if (write_s && !(cZ[k] && w == 0)) begin
        mreg[k][w]  = m_dat(k);
        mbusy[k][w] = 1'b0;
      end
      if (acc && !(cZ[k] && d == 0)) mbusy[k][d] = 1'b1;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("a%0d", k), out_a[k], m_read(k, ix(k, rs_s)));
      chk($sformatf("b%0d", k), out_b[k], m_read(k, ix(k, rt_s)));
      chk($sformatf("stall%0d", k), 32'(out_stall[k]), 32'(m_stall(k)));
      chk($sformatf("busy_vec%0d", k), out_busy[k], m_busyvec(k));
    end
  endtask

  // Check at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    @(negedge Clk);
    compare_all();
    model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    rs_s = 0; rt_s = 0; use_rs_s = 0; use_rt_s = 0;
    issue_valid_s = 0; issue_rd_s = 0; write_s = 0; rd_s = 0; data_s = 0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_a%0d", k), out_a[k], 32'h0);
      chk($sformatf("rst_b%0d", k), out_b[k], 32'h0);
      chk($sformatf("rst_stall%0d", k), 32'(out_stall[k]), 32'h0);
      chk($sformatf("rst_busy%0d", k), out_busy[k], 32'h0);
    end
    model_clear();
    #1 rst = 1'b0;
  endtask

  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
  endfunction

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    #1;
    chk("por_a0", out_a[0], 32'h0);
    chk("por_busy0", out_busy[0], 32'h0);
    chk("por_stall0", 32'(out_stall[0]), 32'h0);
    #1 rst = 1'b0;
    cycle();

    // Load r5, mark r7 busy, then reset between edges.
    write_s = 1; rd_s = 5; data_s = 32'h1234; cycle();
    idle(); issue_valid_s = 1; issue_rd_s = 7; cycle();
    idle(); rs_s = 5; #1;
    chk("pre_rst_a0", out_a[0], 32'h1234);
    chk("pre_rst_busy0", out_busy[0], 32'h80);
    rst_pulse();
    chk("post_rst_a0", out_a[0], 32'h0);
    cycle();

    // Zero register ignores writes and issues.
    idle(); write_s = 1; rd_s = 0; data_s = 32'hFFFF_FFFF; cycle();
    idle(); rs_s = 0; #1;
    chk("zero_a0", out_a[0], 32'h0);
    chk("nozero_a2", out_a[2], 32'h0000_FFFF);
    issue_valid_s = 1; issue_rd_s = 0; cycle();
    idle(); #1;
    chk("zero_busy0", out_busy[0], 32'h0);
    cycle();

    // Bypass vs. no bypass on a same-cycle write-back.
    write_s = 1; rd_s = 3; data_s = 32'h1111; cycle();
    idle(); write_s = 1; rd_s = 3; data_s = 32'hCAFE; rs_s = 3; #1;
    chk("byp_a0", out_a[0], 32'hCAFE);
    chk("nobyp_a1", out_a[1], 32'h1111);
    cycle();
    idle(); rs_s = 3; #1;
    chk("nobyp_next_a1", out_a[1], 32'hCAFE);
    cycle();

    // RAW on an in-flight r8.
    idle(); issue_valid_s = 1; issue_rd_s = 8; cycle();
    idle(); use_rs_s = 1; rs_s = 8; #1;
    chk("raw_stall0", 32'(out_stall[0]), 32'h1);
    cycle();
    write_s = 1; rd_s = 8; data_s = 32'hBEEF; #1;
    chk("raw_wb_stall0", 32'(out_stall[0]), 32'h0);
    chk("raw_wb_a0", out_a[0], 32'hBEEF);
    chk("raw_wb_stall1", 32'(out_stall[1]), 32'h1);
    cycle();
    write_s = 0; #1;
    chk("raw_after_stall1", 32'(out_stall[1]), 32'h0);
    chk("raw_after_a1", out_a[1], 32'hBEEF);
    cycle();

    // WAW guard and set-over-clear priority.
    idle(); issue_valid_s = 1; issue_rd_s = 9; cycle();
    #1;
    chk("waw_stall0", 32'(out_stall[0]), 32'h1);
    cycle();
    write_s = 1; rd_s = 9; data_s = 32'h99; #1;
    chk("prio_stall0", 32'(out_stall[0]), 32'h0);
    cycle();
    idle(); #1;
    chk("prio_busy9_0", out_busy[0] & 32'h200, 32'h200);
    chk("prio_busy9_1", out_busy[1] & 32'h200, 32'h0);
    cycle();

    // Fill the 8-deep file and read each entry back on both ports.
    for (int i = 0; i < 8; i++) begin
      idle(); write_s = 1; rd_s = 5'(i); data_s = 32'(i * 32'h0101); cycle();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); rs_s = 5'(i); rt_s = 5'(7 - i); #1;
      chk($sformatf("fill_a2_%0d", i), out_a[2], 32'(i * 32'h0101));
      chk($sformatf("fill_b2_%0d", i), out_b[2], 32'((7 - i) * 32'h0101));
      cycle();
    end
    idle(); write_s = 1; rd_s = 7; data_s = 32'h7777; cycle();
    idle(); #1;
    chk("wb_nonbusy_busy2", out_busy[2], 32'h0);
    cycle();

    // Randomised traffic with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      rs_s          = rnd_idx();
      rt_s          = rnd_idx();
      use_rs_s      = ($urandom_range(0, 9) < 6);
      use_rt_s      = ($urandom_range(0, 9) < 6);
      issue_valid_s = ($urandom_range(0, 9) < 4);
      issue_rd_s    = rnd_idx();
      write_s       = ($urandom_range(0, 9) < 4);
      rd_s          = rnd_idx();
      data_s        = $urandom;
      if ($urandom_range(0, 199) == 0) rst_pulse();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
